// File: rtl/alu_pkg.sv
// alu_pipe shared definitions.
// Opcode encodings and widths.
package alu_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_SUB = 3'b001;
  localparam op_t OP_AND = 3'b010;
  localparam op_t OP_OR  = 3'b011;
  localparam op_t OP_XOR = 3'b100;
  localparam op_t OP_NOT = 3'b101;
  localparam op_t OP_SHL = 3'b110;
  localparam op_t OP_SHR = 3'b111;

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe combinational datapath.
// a, b, op -> result, carry, zero.
import alu_pkg::*;

module alu_pipe_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Opcode decode; the extra MSB of diff is the borrow.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      (op == OP_SUB): begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      (op == OP_AND): result = a & b;
      (op == OP_OR):  result = a | b;
      (op == OP_XOR): result = a ^ b;
      (op == OP_NOT): result = ~a;
      (op == OP_SHL): begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      (op == OP_SHR): begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage registered ALU.
// Valid/ready in and out, response counter.
import alu_pkg::*;

module alu_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic [CNT_W-1:0] resp_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_t              s1_op;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_carry;
  logic             s2_zero;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_zero;

  logic             s1_adv;
  logic             s2_adv;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  alu_pipe_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .carry  (core_carry),
    .zero   (core_zero)
  );

  // Stage 1: capture operands when the stage can move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= in_op;
      end
    end
  end

  // Stage 2: register ALU outputs; frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_carry  <= 1'b0;
      s2_zero   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= core_result;
        s2_carry  <= core_carry;
        s2_zero   <= core_zero;
      end
    end
  end

  // Count responses taken downstream; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_count <= '0;
    end else if (s2_valid && out_ready) begin
      resp_count <= resp_count + CNT_W'(1);
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_carry  = s2_carry;
  assign out_zero   = s2_zero;

endmodule
